// File: rtl/memory_access_if.sv
// -----------------------------------------------------------------------------
// memory_access_if
// Pipeline register types shared by the MEM stage and its neighbours, plus the
// data-bus interface between the MEM stage (master) and the memory system
// (slave).
//
// REG_EX_MEM : EX->MEM pipeline register (input of memory_access)
// REG_MEM_WB : MEM->WB pipeline register (output of memory_access)
//
// Interface signals:
//   dreq_valid    master->slave  request valid, held until dresp_data_ok
//   dreq_addr     master->slave  byte address
//   dreq_size     master->slave  log2 of access size in bytes (0=B .. 3=D)
//   dreq_strobe   master->slave  byte enables, all zero for a read
//   dreq_data     master->slave  store data, lane aligned
//   dresp_addr_ok slave->master  address accepted
//   dresp_data_ok slave->master  transaction complete
//   dresp_data    slave->master  read data, lane aligned
// -----------------------------------------------------------------------------

typedef struct packed {
    logic        valid;
    logic        isMem;
    logic        memWrite;
    logic        memSigned;
    logic [2:0]  memSize;
    logic        isWriteBack;
    logic        isJump;
    logic        isBranch;
    logic        branchAdopted;
    logic [63:0] aluOut;
    logic [63:0] rs2;
    logic [63:0] pcPlus4;
    logic [4:0]  wd;
    logic [31:0] instr;
    logic [63:0] instrAddr;
} REG_EX_MEM;

typedef struct packed {
    logic        valid;
    logic        isMem;
    logic        isWriteBack;
    logic        isJump;
    logic        isBranch;
    logic        branchAdopted;
    logic [63:0] aluOut;
    logic [63:0] memOut;
    logic [63:0] memAddr;
    logic [63:0] pcPlus4;
    logic [4:0]  wd;
    logic [31:0] instr;
    logic [63:0] instrAddr;
} REG_MEM_WB;

interface memory_access_if #(
    parameter int XLEN      = 64,
    parameter int BUS_BYTES = 8
);
    logic                 dreq_valid;
    logic [XLEN-1:0]      dreq_addr;
    logic [2:0]           dreq_size;
    logic [BUS_BYTES-1:0] dreq_strobe;
    logic [XLEN-1:0]      dreq_data;
    logic                 dresp_addr_ok;
    logic                 dresp_data_ok;
    logic [XLEN-1:0]      dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// MEM stage of the 5-stage core. Takes the EX->MEM register, issues one data
// bus transaction per load/store, formats load data and registers the MEM->WB
// register. Takes part in the global stall handshake.
//
// Ports:
//   clk                   core clock
//   rst                   synchronous active-high reset
//   moduleIn              EX->MEM pipeline register
//   moduleOut             MEM->WB pipeline register (registered)
//   bus                   data bus, master side
//   ok_to_proceed         this stage has its result ready
//   ok_to_proceed_overall every stage ready: advance the pipeline
//   misalign              (MEM_MISALIGN_CHECK_EN only) pulses with
//                         moduleOut.valid for a misaligned access
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to suppress bus requests for
// accesses not aligned to their size and flag them on the misalign port.
// -----------------------------------------------------------------------------

module memory_access #(
    parameter int XLEN      = 64,
    parameter int BUS_BYTES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  REG_EX_MEM       moduleIn,
    output REG_MEM_WB       moduleOut,
    memory_access_if.master bus,
    output logic            ok_to_proceed,
    input  logic            ok_to_proceed_overall
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic            misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_is_mem_in;
    logic                 w_misaligned_in;
    logic                 w_start_req;
    logic                 w_advance;
    logic                 w_misal_flag;
    REG_MEM_WB            w_result;

    logic                 r_dreq_valid;
    logic [XLEN-1:0]      r_dreq_addr;
    logic [2:0]           r_dreq_size;
    logic [BUS_BYTES-1:0] r_dreq_strobe;
    logic [XLEN-1:0]      r_dreq_data;
    logic                 r_is_write;
    logic                 r_signed;
    logic [XLEN-1:0]      r_mem_out;
    logic                 r_addr_ok_seen;
    REG_MEM_WB            r_module_out;

    // Byte enables for an access of 2**size bytes starting at lane off; lanes
    // past the top of the bus are dropped.
    function automatic logic [BUS_BYTES-1:0] f_strobe(input logic [1:0] size,
                                                      input logic [2:0] off);
        logic [BUS_BYTES-1:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    // Shift the addressed lanes down, truncate to the access size and extend.
    function automatic logic [XLEN-1:0] f_load(input logic [XLEN-1:0] dat,
                                               input logic [1:0]      size,
                                               input logic [2:0]      off,
                                               input logic            sgn);
        logic [XLEN-1:0] raw;
        logic [XLEN-1:0] res;
        raw = dat >> {off, 3'b000};
        case (size)
            2'd0:    res = {{(XLEN-8){sgn & raw[7]}}, raw[7:0]};
            2'd1:    res = {{(XLEN-16){sgn & raw[15]}}, raw[15:0]};
            2'd2:    res = {{(XLEN-32){sgn & raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    // True when the low address bits are not a multiple of the access size.
    function automatic logic f_misaligned(input logic [1:0] size,
                                          input logic [2:0] off);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = off[0];
            2'd2:    bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction
`endif

    assign w_is_mem_in = moduleIn.valid & moduleIn.isMem;

    // Decode of the incoming access: misalignment and whether to start a bus request
    always_comb begin
`ifdef MEM_MISALIGN_CHECK_EN
        w_misaligned_in = f_misaligned(moduleIn.memSize[1:0], moduleIn.aluOut[2:0]);
`else
        w_misaligned_in = 1'b0;
`endif
        w_start_req = (r_state == S_IDLE) & w_is_mem_in & ~w_misaligned_in;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and ready decode
    always_comb begin
        w_state_next  = r_state;
        ok_to_proceed = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Non-memory or bubble: passes straight through this stage
                ok_to_proceed = ~w_is_mem_in;
                if (w_is_mem_in) begin
                    w_state_next = w_misaligned_in ? S_DONE : S_REQ;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.dresp_data_ok) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_REQ;
                end
            end
            S_DONE: begin
                ok_to_proceed = 1'b1;
                if (ok_to_proceed_overall) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_advance = ok_to_proceed & ok_to_proceed_overall;

    // Bus request registers and load-result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dreq_valid   <= 1'b0;
            r_dreq_addr    <= 64'd0;
            r_dreq_size    <= 3'd0;
            r_dreq_strobe  <= 8'h00;
            r_dreq_data    <= 64'd0;
            r_is_write     <= 1'b0;
            r_signed       <= 1'b0;
            r_mem_out      <= 64'd0;
            r_addr_ok_seen <= 1'b0;
        end else if (r_state == S_IDLE && w_is_mem_in) begin
            r_mem_out      <= 64'd0;
            r_addr_ok_seen <= 1'b0;
            if (w_start_req) begin
                r_dreq_valid  <= 1'b1;
                r_dreq_addr   <= moduleIn.aluOut;
                r_dreq_size   <= moduleIn.memSize;
                r_dreq_strobe <= moduleIn.memWrite
                               ? f_strobe(moduleIn.memSize[1:0], moduleIn.aluOut[2:0])
                               : 8'h00;
                r_dreq_data   <= moduleIn.rs2 << {moduleIn.aluOut[2:0], 3'b000};
                r_is_write    <= moduleIn.memWrite;
                r_signed      <= moduleIn.memSigned;
            end
        end else if (r_state == S_REQ) begin
            if (bus.dresp_addr_ok) begin
                r_addr_ok_seen <= 1'b1;
            end
            if (bus.dresp_data_ok) begin
                r_dreq_valid <= 1'b0;
                r_mem_out    <= r_is_write ? 64'd0
                              : f_load(bus.dresp_data, r_dreq_size[1:0],
                                       r_dreq_addr[2:0], r_signed);
            end
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic r_misal_pend;
    logic r_misalign;

    // Remember a misaligned access until it leaves, then pulse alongside its valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misal_pend <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_misalign <= w_advance & r_misal_pend;
            if (r_state == S_IDLE && w_is_mem_in && w_misaligned_in) begin
                r_misal_pend <= 1'b1;
            end else if (w_advance) begin
                r_misal_pend <= 1'b0;
            end
        end
    end

    assign w_misal_flag = r_misal_pend;
    assign misalign     = r_misalign;
`else
    assign w_misal_flag = 1'b0;
`endif

    // Result handed to writeback when the pipeline advances
    always_comb begin
        w_result               = '0;
        w_result.valid         = moduleIn.valid;
        w_result.isMem         = moduleIn.isMem;
        w_result.isWriteBack   = moduleIn.isWriteBack & ~w_misal_flag;
        w_result.isJump        = moduleIn.isJump;
        w_result.isBranch      = moduleIn.isBranch;
        w_result.branchAdopted = moduleIn.branchAdopted;
        w_result.aluOut        = moduleIn.aluOut;
        w_result.memOut        = (r_state == S_DONE) ? r_mem_out : 64'd0;
        w_result.memAddr       = moduleIn.aluOut;
        w_result.pcPlus4       = moduleIn.pcPlus4;
        w_result.wd            = moduleIn.wd;
        w_result.instr         = moduleIn.instr;
        w_result.instrAddr     = moduleIn.instrAddr;
    end

    // MEM->WB register: load on advance, otherwise insert a bubble and hold fields
    always_ff @(posedge clk) begin
        if (rst) begin
            r_module_out <= '0;
        end else if (w_advance) begin
            r_module_out <= w_result;
        end else begin
            r_module_out.valid <= 1'b0;
        end
    end

    // Protocol checks: no advance before ready; completion never precedes address acceptance
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (ok_to_proceed || !ok_to_proceed_overall);
            assert (!(r_state == S_REQ && bus.dresp_data_ok) || bus.dresp_addr_ok || r_addr_ok_seen);
        end
    end

    assign moduleOut       = r_module_out;
    assign bus.dreq_valid  = r_dreq_valid;
    assign bus.dreq_addr   = r_dreq_addr;
    assign bus.dreq_size   = r_dreq_size;
    assign bus.dreq_strobe = r_dreq_strobe;
    assign bus.dreq_data   = r_dreq_data;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    logic      clk = 1'b0;
    logic      rst;
    REG_EX_MEM mi;
    REG_MEM_WB mo;
    logic      okp;
    logic      ovr;
`ifdef MEM_MISALIGN_CHECK_EN
    logic      misal;
`endif

    memory_access_if bus ();

    memory_access dut (
        .clk                   (clk),
        .rst                   (rst),
        .moduleIn              (mi),
        .moduleOut             (mo),
        .bus                   (bus),
        .ok_to_proceed         (okp),
        .ok_to_proceed_overall (ovr)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign              (misal)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte enables as the set of lanes touched by the access
    function automatic logic [7:0] m_strobe(input logic [63:0] addr, input int nb);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < nb; i++)
            if (int'(addr[2:0]) + i < 8) s[int'(addr[2:0]) + i] = 1'b1;
        return s;
    endfunction

    // Reference: gather the addressed bytes one by one, then extend
    function automatic logic [63:0] m_load(input logic [63:0] dw, input logic [63:0] addr,
                                           input int nb, input bit sgn);
        logic [63:0] r;
        int lane;
        r = 64'd0;
        for (int i = 0; i < nb; i++) begin
            lane = int'(addr[2:0]) + i;
            if (lane < 8) r[i*8 +: 8] = dw[lane*8 +: 8];
        end
        if (sgn && r[nb*8-1])
            for (int j = nb*8; j < 64; j++) r[j] = 1'b1;
        return r;
    endfunction

    // One memory instruction through the stage with a bus that accepts the
    // address after alat cycles and completes after dlat cycles.
    task automatic mem_txn(input string tag, input logic wr, input logic sgn,
                           input logic [2:0] sz, input logic [63:0] addr,
                           input logic [63:0] rs2, input logic [63:0] dw,
                           input int alat, input int dlat,
                           input logic [7:0] e_strb, input logic [63:0] e_data,
                           input logic [63:0] e_out);
        REG_EX_MEM in;
        int  c;
        bit  stable;
        bit  done;
        in               = '0;
        in.valid         = 1'b1;
        in.isMem         = 1'b1;
        in.memWrite      = wr;
        in.memSigned     = sgn;
        in.memSize       = sz;
        in.isWriteBack   = ~wr;
        in.aluOut        = addr;
        in.rs2           = rs2;
        in.pcPlus4       = 64'h0000_0000_0000_1004;
        in.wd            = 5'd9;
        in.instr         = 32'h0005_3503;
        in.instrAddr     = 64'h0000_0000_0000_1000;
        @(negedge clk);
        mi  = in;
        ovr = 1'b0;
        #1;
        chk({tag, " ok_idle"}, {63'd0, okp}, 64'd0);
        @(negedge clk);
        chk({tag, " dreq_valid"}, {63'd0, bus.dreq_valid}, 64'd1);
        chk({tag, " dreq_addr"}, bus.dreq_addr, addr);
        chk({tag, " dreq_size"}, {61'd0, bus.dreq_size}, {61'd0, sz});
        chk({tag, " dreq_strobe"}, {56'd0, bus.dreq_strobe}, {56'd0, e_strb});
        if (wr) chk({tag, " dreq_data"}, bus.dreq_data, e_data);
        stable = 1'b1;
        c      = 0;
        done   = 1'b0;
        while (!done) begin
            if (bus.dreq_valid !== 1'b1 || bus.dreq_addr !== addr ||
                bus.dreq_strobe !== e_strb || (wr && bus.dreq_data !== e_data))
                stable = 1'b0;
            bus.dresp_addr_ok = (c == alat);
            bus.dresp_data_ok = (c == dlat);
            bus.dresp_data    = (c == dlat) ? dw : {$urandom, $urandom};
            @(negedge clk);
            bus.dresp_addr_ok = 1'b0;
            bus.dresp_data_ok = 1'b0;
            if (c == dlat) done = 1'b1;
            else c++;
        end
        chk({tag, " req_stable"}, {63'd0, stable}, 64'd1);
        chk({tag, " ok_done"}, {63'd0, okp}, 64'd1);
        chk({tag, " dreq_drop"}, {63'd0, bus.dreq_valid}, 64'd0);
        ovr = 1'b1;
        @(negedge clk);
        ovr = 1'b0;
        mi  = '0;
        chk({tag, " out_valid"}, {63'd0, mo.valid}, 64'd1);
        if (!wr) chk({tag, " memOut"}, mo.memOut, e_out);
        chk({tag, " memAddr"}, mo.memAddr, addr);
        chk({tag, " isWriteBack"}, {63'd0, mo.isWriteBack}, {63'd0, ~wr});
        @(negedge clk);
        chk({tag, " out_bubble"}, {63'd0, mo.valid}, 64'd0);
    endtask

    // One non-memory (or invalid) instruction: zero cycles in the stage.
    task automatic alu_txn(input string tag, input REG_EX_MEM in);
        @(negedge clk);
        mi  = in;
        ovr = 1'b0;
        #1;
        chk({tag, " ok"}, {63'd0, okp}, 64'd1);
        chk({tag, " no_dreq"}, {63'd0, bus.dreq_valid}, 64'd0);
        ovr = 1'b1;
        @(negedge clk);
        ovr = 1'b0;
        mi  = '0;
        chk({tag, " valid"}, {63'd0, mo.valid}, {63'd0, in.valid});
        chk({tag, " aluOut"}, mo.aluOut, in.aluOut);
        chk({tag, " pcPlus4"}, mo.pcPlus4, in.pcPlus4);
        chk({tag, " wd_instr"}, {27'd0, mo.wd, mo.instr}, {27'd0, in.wd, in.instr});
        chk({tag, " flags"}, {60'd0, mo.isJump, mo.isBranch, mo.branchAdopted, mo.isWriteBack},
            {60'd0, in.isJump, in.isBranch, in.branchAdopted, in.isWriteBack});
    endtask

    typedef struct {
        bit          is_mem;
        logic        wr;
        logic        sgn;
        logic [2:0]  sz;
        logic [63:0] addr;
        logic [63:0] rs2;
        logic [63:0] dw;
        int          alat;
        int          dlat;
        logic [7:0]  e_strb;
        logic [63:0] e_data;
        logic [63:0] e_out;
    } vec_t;

    vec_t tbl[8];

    initial begin
        REG_EX_MEM   in;
        logic [2:0]  sz;
        int          nb;
        int          off;
        int          alat;
        logic        wr;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] rs2;
        logic [63:0] dw;

        //            mem wr   sgn  sz    addr                    rs2                     bus dword               al dl strobe e_data                  e_memOut
        tbl[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 64'h0000_0000_0000_0005, 64'd0,                  64'd0,                  0, 0, 8'h00, 64'd0,                  64'h0000_0000_0000_0005};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 3'd0, 64'h0000_0000_8000_0003, 64'd0,                  64'h0000_0000_80FF_0000, 1, 3, 8'h00, 64'd0,                  64'hFFFF_FFFF_FFFF_FF80};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 3'd1, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_1234, 64'd0,                  2, 4, 8'hC0, 64'h1234_0000_0000_0000, 64'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 3'd2, 64'h0000_0000_8000_0000, 64'd0,                  64'h0000_0000_8000_0000, 0, 0, 8'h00, 64'd0,                  64'h0000_0000_8000_0000};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 3'd1, 64'h0000_0000_8000_0002, 64'd0,                  64'h1122_3344_5566_7788, 0, 1, 8'h00, 64'd0,                  64'h0000_0000_0000_5566};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 3'd2, 64'h0000_0000_8000_0004, 64'd0,                  64'h8765_4321_0000_0000, 1, 1, 8'h00, 64'd0,                  64'hFFFF_FFFF_8765_4321};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 3'd3, 64'h0000_0000_8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 64'd0,                  0, 2, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'd0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 3'd0, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB, 64'd0,                  0, 0, 8'h20, 64'h0000_AB00_0000_0000, 64'd0};

        rst               = 1'b1;
        mi                = '0;
        ovr               = 1'b0;
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = 64'd0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", {63'd0, mo.valid}, 64'd0);
        chk("reset dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
        chk("reset strobe", {56'd0, bus.dreq_strobe}, 64'd0);
        chk("reset ok_idle", {63'd0, okp}, 64'd1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_mem) begin
                mem_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].sgn, tbl[i].sz, tbl[i].addr,
                        tbl[i].rs2, tbl[i].dw, tbl[i].alat, tbl[i].dlat,
                        tbl[i].e_strb, tbl[i].e_data, tbl[i].e_out);
            end else begin
                in           = '0;
                in.valid     = 1'b1;
                in.aluOut    = tbl[i].addr;
                in.pcPlus4   = 64'h0000_0000_0000_2004;
                in.wd        = 5'd3;
                in.instr     = 32'h0050_0193;
                in.instrAddr = 64'h0000_0000_0000_2000;
                in.isWriteBack = 1'b1;
                alu_txn($sformatf("vec%0d", i), in);
                chk($sformatf("vec%0d aluOut_exp", i), mo.aluOut, tbl[i].e_out);
            end
        end

        // Reset while a request is outstanding; a late completion must be ignored
        in         = '0;
        in.valid   = 1'b1;
        in.isMem   = 1'b1;
        in.memSize = 3'd2;
        in.aluOut  = 64'h0000_0000_8000_0010;
        @(negedge clk);
        mi = in;
        @(negedge clk);
        chk("rstreq pre_valid", {63'd0, bus.dreq_valid}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstreq dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
        chk("rstreq out_valid", {63'd0, mo.valid}, 64'd0);
        rst               = 1'b0;
        mi                = '0;
        bus.dresp_addr_ok = 1'b1;
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        chk("rstreq late_dreq", {63'd0, bus.dreq_valid}, 64'd0);
        chk("rstreq late_out", {63'd0, mo.valid}, 64'd0);
        chk("rstreq idle_ok", {63'd0, okp}, 64'd1);

        // Doubleword load at a 4-byte offset
`ifdef MEM_MISALIGN_CHECK_EN
        in             = '0;
        in.valid       = 1'b1;
        in.isMem       = 1'b1;
        in.memSize     = 3'd3;
        in.isWriteBack = 1'b1;
        in.aluOut      = 64'h0000_0000_8000_0004;
        @(negedge clk);
        mi = in;
        #1;
        chk("mis ok_idle", {63'd0, okp}, 64'd0);
        @(negedge clk);
        chk("mis no_dreq", {63'd0, bus.dreq_valid}, 64'd0);
        chk("mis ok_done", {63'd0, okp}, 64'd1);
        ovr = 1'b1;
        @(negedge clk);
        ovr = 1'b0;
        mi  = '0;
        chk("mis out_valid", {63'd0, mo.valid}, 64'd1);
        chk("mis isWriteBack", {63'd0, mo.isWriteBack}, 64'd0);
        chk("mis flag", {63'd0, misal}, 64'd1);
        @(negedge clk);
        chk("mis flag_drop", {63'd0, misal}, 64'd0);
`else
        mem_txn("ld_off4", 1'b0, 1'b0, 3'd3, 64'h0000_0000_8000_0004, 64'd0,
                64'h0123_4567_89AB_CDEF, 0, 1, 8'h00, 64'd0, 64'h0000_0000_0123_4567);
`endif

        // Randomized traffic checked against the byte-level reference
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                in               = '0;
                in.valid         = 1'($urandom_range(0, 1));
                in.isMem         = in.valid ? 1'b0 : 1'($urandom_range(0, 1));
                in.isWriteBack   = 1'($urandom_range(0, 1));
                in.isJump        = 1'($urandom_range(0, 1));
                in.isBranch      = 1'($urandom_range(0, 1));
                in.branchAdopted = 1'($urandom_range(0, 1));
                in.aluOut        = {$urandom, $urandom};
                in.pcPlus4       = {$urandom, $urandom};
                in.wd            = 5'($urandom_range(0, 31));
                in.instr         = $urandom;
                in.instrAddr     = {$urandom, $urandom};
                alu_txn($sformatf("rnd%0d", k), in);
            end else begin
                sz   = 3'($urandom_range(0, 3));
                nb   = 1 << sz;
                off  = $urandom_range(0, 8 / nb - 1) * nb;
                addr = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 255) * 8 + off);
                wr   = 1'($urandom_range(0, 1));
                sgn  = 1'($urandom_range(0, 1));
                rs2  = {$urandom, $urandom};
                dw   = {$urandom, $urandom};
                alat = $urandom_range(0, 2);
                mem_txn($sformatf("rnd%0d", k), wr, sgn, sz, addr, rs2, dw, alat,
                        alat + $urandom_range(0, 3),
                        wr ? m_strobe(addr, nb) : 8'h00,
                        rs2 << (8 * off),
                        m_load(dw, addr, nb, sgn));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
